fetch_unit: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the decode stage's IF/ID register.
- Owns the fetch PC and talks to a variable-latency instruction memory through a req/ready handshake.
- Buffers fetched instructions in a small prefetch queue and presents them to decode together with PC+2.
- Redirects on taken branch/jump, holds on decode stall, and stops fetching after halt.

---
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch unit, the instruction memory and decode.
// The fetch unit drives through master; the memory/decode side uses slave.
interface fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        halt;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc_inc;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc_inc,
    input  imem_ready, imem_data, redirect, redirect_pc, stall, halt
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc_inc,
    output imem_ready, imem_data, redirect, redirect_pc, stall, halt
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, fetches through a non-committing
// req/ready memory port and feeds decode from a small circular prefetch queue.
module fetch_unit #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {ST_RUN, ST_HALTED} state_t;

  state_t          state_q, state_d;
  logic [15:0]     pc_q, pc_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [15:0]     instr_mem_q [DEPTH];
  logic [15:0]     pcinc_mem_q [DEPTH];

  logic            not_empty;
  logic            push;
  logic            pop;

  assign not_empty     = (count_q != '0);
  // Gated with rst so the request is low while reset is held, not just after it.
  assign bus.imem_req  = rst && (state_q == ST_RUN) && (count_q < CW'(DEPTH));
  assign bus.imem_addr = pc_q;

  assign push          = bus.imem_req && bus.imem_ready && !bus.redirect;
  assign bus.if_valid  = not_empty && !bus.redirect;
  assign pop           = bus.if_valid && !bus.stall;

  assign bus.if_instr  = not_empty ? instr_mem_q[rd_ptr_q] : NOP_INSTR;
  assign bus.if_pc_inc = not_empty ? pcinc_mem_q[rd_ptr_q] : 16'h0000;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (bus.halt) begin
      state_d = ST_HALTED;
    end

    // A redirect overrides everything: flush, drop the response, load the new PC.
    if (bus.redirect) begin
      pc_d     = bus.redirect_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 16'd2;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= bus.imem_data;
      pcinc_mem_q[wr_ptr_q] <= pc_q + 16'd2;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Cycle-level bench for fetch_unit: a wait-state memory model drives the port and a
// scoreboard of expected {instr, pc_inc} entries is checked against decode each cycle.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if ifc ();

  fetch_unit #(
    .DEPTH(4),
    .RESET_PC(16'h0000),
    .NOP_INSTR(16'h0800)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int          err_cnt = 0;
  int          chk_cnt = 0;

  logic [31:0] exp_q[$];
  logic [15:0] m_pc;
  logic        m_halt;
  int          ws;
  int          wait_cnt;
  logic        force_ready;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {8'hA0, a[7:0]};
  endfunction

  task automatic step();
    logic        m_req, m_valid, acc, pp, req_pre, rdy_pre;
    logic [31:0] head;
    @(negedge clk);
    ifc.imem_ready = (ifc.imem_req && (wait_cnt >= ws)) || force_ready;
    ifc.imem_data  = mem_word(ifc.imem_addr);
    #1;
    m_req   = !m_halt && (exp_q.size() < 4);
    m_valid = (exp_q.size() != 0) && !ifc.redirect;
    head    = (exp_q.size() != 0) ? exp_q[0] : {16'h0800, 16'h0000};
    check_eq("imem_req",  {31'd0, ifc.imem_req}, {31'd0, m_req});
    check_eq("imem_addr", {16'd0, ifc.imem_addr}, {16'd0, m_pc});
    check_eq("if_valid",  {31'd0, ifc.if_valid}, {31'd0, m_valid});
    check_eq("if_instr",  {16'd0, ifc.if_instr}, {16'd0, head[31:16]});
    check_eq("if_pc_inc", {16'd0, ifc.if_pc_inc}, {16'd0, head[15:0]});
    acc     = m_req && ifc.imem_ready && !ifc.redirect;
    pp      = m_valid && !ifc.stall;
    req_pre = ifc.imem_req;
    rdy_pre = ifc.imem_ready;
    if (pp) $display("decode: instr=%h pc_inc=%h", ifc.if_instr, ifc.if_pc_inc);
    @(posedge clk);
    #1;
    if (ifc.redirect) begin
      exp_q.delete();
      m_pc = ifc.redirect_pc;
    end else begin
      if (pp) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back({mem_word(m_pc), m_pc + 16'd2});
        m_pc = m_pc + 16'd2;
      end
    end
    m_halt = m_halt | ifc.halt;
    if (req_pre && !rdy_pre && !ifc.redirect) wait_cnt++;
    else wait_cnt = 0;
  endtask

  // Assert reset between clock edges, check outputs respond without a clock, then release.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_eq("rst_req",   {31'd0, ifc.imem_req}, 32'd0);
    check_eq("rst_addr",  {16'd0, ifc.imem_addr}, 32'h0000);
    check_eq("rst_valid", {31'd0, ifc.if_valid}, 32'd0);
    check_eq("rst_instr", {16'd0, ifc.if_instr}, 32'h0800);
    check_eq("rst_pcinc", {16'd0, ifc.if_pc_inc}, 32'h0000);
    ifc.redirect    = 1'b0;
    ifc.redirect_pc = 16'h0000;
    ifc.stall       = 1'b0;
    ifc.halt        = 1'b0;
    ifc.imem_ready  = 1'b0;
    ifc.imem_data   = 16'h0000;
    force_ready     = 1'b0;
    exp_q.delete();
    m_pc     = 16'h0000;
    m_halt   = 1'b0;
    wait_cnt = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    ifc.redirect    = 1'b0;
    ifc.redirect_pc = 16'h0000;
    ifc.stall       = 1'b0;
    ifc.halt        = 1'b0;
    ifc.imem_ready  = 1'b0;
    ifc.imem_data   = 16'h0000;
    force_ready     = 1'b0;
    ws              = 0;
    wait_cnt        = 0;
    m_pc            = 16'h0000;
    m_halt          = 1'b0;

    // Zero-wait sequential fetch.
    apply_reset();
    repeat (8) step();

    // Three wait states per fetch.
    ws = 3;
    apply_reset();
    repeat (16) step();

    // Stall from reset until full, then drain while fetch resumes.
    ws = 0;
    apply_reset();
    ifc.stall = 1'b1;
    repeat (10) step();
    ifc.stall = 1'b0;
    repeat (6) step();

    // Full queue hit by a redirect with a same-cycle ready.
    apply_reset();
    ifc.stall = 1'b1;
    repeat (6) step();
    ifc.redirect    = 1'b1;
    ifc.redirect_pc = 16'h0040;
    force_ready     = 1'b1;
    step();
    ifc.redirect = 1'b0;
    force_ready  = 1'b0;
    ifc.stall    = 1'b0;
    repeat (8) step();

    // Halt with entries queued: drain, then stay idle even across a redirect.
    apply_reset();
    ifc.stall = 1'b1;
    repeat (2) step();
    ifc.halt = 1'b1;
    step();
    ifc.halt  = 1'b0;
    ifc.stall = 1'b0;
    repeat (6) step();
    ifc.redirect    = 1'b1;
    ifc.redirect_pc = 16'h0020;
    step();
    ifc.redirect = 1'b0;
    repeat (4) step();

    // Reset in the middle of a waited fetch, then PC wrap at FFFE.
    ws = 3;
    apply_reset();
    repeat (2) step();
    ws = 0;
    apply_reset();
    ifc.redirect    = 1'b1;
    ifc.redirect_pc = 16'hFFFE;
    step();
    ifc.redirect = 1'b0;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
